// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   uart_state_e          : 3-bit frame FSM encoding (IDLE=0 .. DONE=4), same on both sides
//   UartClksPerBit        : default clocks per bit (115200 baud at 50 MHz)
//   UartDataWidth         : data bits per frame
package uart_pkg;

  localparam int unsigned UartClksPerBit = 434;
  localparam int unsigned UartDataWidth  = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StDone  = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
//   clk : system clock
//   rst : synchronous active-high reset, both stages go to 1
//   d_i : asynchronous input
//   q_o : synchronized output
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples rx with clk, finds the start edge and samples the start,
// data (LSB first) and stop bits at mid-bit, then strobes the received byte for one cycle.
//   CLKS_PER_BIT  : clocks per bit period, >= 4
//   clk           : system clock
//   rst           : synchronous active-high reset
//   rx            : asynchronous serial input, idle high
//   RX_BYTE       : last received byte, held until the next RX_DATA_VALID
//   RX_DATA_VALID : one-cycle strobe, RX_BYTE valid in that cycle
//   O_RX_FERR     : one-cycle framing-error strobe
// Build option UART_RX_FRAMING_ERR_EN: when defined, a low stop bit raises O_RX_FERR instead
// of RX_DATA_VALID and leaves RX_BYTE untouched. When undefined the stop bit is ignored and
// O_RX_FERR is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartClksPerBit
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [UartDataWidth-1:0] RX_BYTE,
  output logic                     RX_DATA_VALID,
  output logic                     O_RX_FERR
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(UartDataWidth);

  localparam logic [CntW-1:0] CntBitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(UartDataWidth - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  uart_state_e              state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [UartDataWidth-1:0] shift_q, shift_d;
  logic [UartDataWidth-1:0] byte_q;
  logic                     stop_q, stop_d;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b1;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      byte_q  <= RX_BYTE;
    end
  end

  // Next-state logic. The counter is cleared at every compare point, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalfLast) begin
          cnt_d   = '0;
          // A line that is high again at mid-start was a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntBitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IdxLast) state_d = StStop;
          else                  idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntBitLast) begin
          cnt_d   = '0;
          stop_d  = rx_s;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifndef UART_RX_FRAMING_ERR_EN
  logic unused_stop;
  assign unused_stop = stop_q;
`endif

  // Outputs. Strobes are gated by rst so a reset coinciding with DONE suppresses them.
  always_comb begin
    RX_DATA_VALID = 1'b0;
    O_RX_FERR     = 1'b0;
    if ((state_q == StDone) && !rst) begin
`ifdef UART_RX_FRAMING_ERR_EN
      RX_DATA_VALID = stop_q;
      O_RX_FERR     = !stop_q;
`else
      RX_DATA_VALID = 1'b1;
`endif
    end
    // Present the new byte in the strobe cycle itself; byte_q holds it afterwards.
    RX_BYTE = RX_DATA_VALID ? shift_q : byte_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned N = 434;
  // Raw fall to strobe: 2 sync cycles + H + 9N + 1.
  localparam int StrobeLat = 4126;
  localparam int FrameLen  = 4340;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int ferr_cnt = 0;
  logic [7:0] got_byte[$];
  int         got_cyc[$];

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .RX_BYTE       (rx_byte),
    .RX_DATA_VALID (rx_valid),
    .O_RX_FERR     (rx_ferr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_byte.push_back(rx_byte);
      got_cyc.push_back(cyc);
    end
    if (rx_ferr) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_byte.delete();
    got_cyc.delete();
    ferr_cnt = 0;
  endtask

  // Serial transmitter model: start, 8 data bits LSB first, stop, each N cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    fall_cyc = cyc;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(N);
    end
    rx = stop_bit;
    tick(N);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rx = 1'b1;
    rst = 1'b1;
    tick(3);
    total++;
    if (rx_byte !== 8'h00) begin
      bad++; $display("FAIL reset_byte got=%h want=00", rx_byte);
    end
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", rx_valid);
    end
    total++;
    if (rx_ferr !== 1'b0) begin
      bad++; $display("FAIL reset_ferr got=%b want=0", rx_ferr);
    end
    total++;
    if (dut.state_q !== StIdle) begin
      bad++; $display("FAIL reset_state got=%0d want=0", dut.state_q);
    end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single_frame();
    int f0;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    f0 = fall_cyc;
    tick(20);
    total++;
    if (got_byte.size() !== 1) begin
      bad++; $display("FAIL single_count got=%0d want=1", got_byte.size());
    end
    if (got_byte.size() >= 1) begin
      total++;
      if (got_byte[0] !== 8'hA5) begin
        bad++; $display("FAIL single_byte got=%h want=a5", got_byte[0]);
      end
      total++;
      if (got_cyc[0] !== f0 + StrobeLat) begin
        bad++; $display("FAIL single_time got=%0d want=%0d", got_cyc[0], f0 + StrobeLat);
      end
    end
    total++;
    if (ferr_cnt !== 0) begin
      bad++; $display("FAIL single_ferr got=%0d want=0", ferr_cnt);
    end
    total++;
    if (rx_byte !== 8'hA5) begin
      bad++; $display("FAIL single_hold got=%h want=a5", rx_byte);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(600);
    total++;
    if (got_byte.size() !== 0) begin
      bad++; $display("FAIL glitch_count got=%0d want=0", got_byte.size());
    end
    total++;
    if (dut.state_q !== StIdle) begin
      bad++; $display("FAIL glitch_state got=%0d want=0", dut.state_q);
    end
    total++;
    if (rx_byte !== 8'hA5) begin
      bad++; $display("FAIL glitch_byte got=%h want=a5", rx_byte);
    end
  endtask

  task automatic test_back_to_back();
    int f1;
    clear_mon();
    send_frame(8'h00, 1'b1);
    f1 = fall_cyc;
    send_frame(8'hFF, 1'b1);
    tick(20);
    total++;
    if (got_byte.size() !== 2) begin
      bad++; $display("FAIL b2b_count got=%0d want=2", got_byte.size());
    end
    if (got_byte.size() >= 2) begin
      total++;
      if (got_byte[0] !== 8'h00) begin
        bad++; $display("FAIL b2b_byte0 got=%h want=00", got_byte[0]);
      end
      total++;
      if (got_byte[1] !== 8'hFF) begin
        bad++; $display("FAIL b2b_byte1 got=%h want=ff", got_byte[1]);
      end
      total++;
      if (got_cyc[1] - got_cyc[0] !== FrameLen) begin
        bad++; $display("FAIL b2b_gap got=%0d want=%0d", got_cyc[1] - got_cyc[0], FrameLen);
      end
      total++;
      if (got_cyc[0] !== f1 + StrobeLat) begin
        bad++; $display("FAIL b2b_time got=%0d want=%0d", got_cyc[0], f1 + StrobeLat);
      end
    end
  endtask

  task automatic test_bad_stop();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    tick(600);
`ifdef UART_RX_FRAMING_ERR_EN
    total++;
    if (ferr_cnt !== 1) begin
      bad++; $display("FAIL badstop_ferr got=%0d want=1", ferr_cnt);
    end
    total++;
    if (got_byte.size() !== 0) begin
      bad++; $display("FAIL badstop_count got=%0d want=0", got_byte.size());
    end
    total++;
    if (rx_byte !== 8'hFF) begin
      bad++; $display("FAIL badstop_hold got=%h want=ff", rx_byte);
    end
`else
    total++;
    if (ferr_cnt !== 0) begin
      bad++; $display("FAIL badstop_ferr got=%0d want=0", ferr_cnt);
    end
    total++;
    if (got_byte.size() !== 1) begin
      bad++; $display("FAIL badstop_count got=%0d want=1", got_byte.size());
    end
    total++;
    if (rx_byte !== 8'h3C) begin
      bad++; $display("FAIL badstop_byte got=%h want=3c", rx_byte);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial;
    partial = 8'hC3;
    clear_mon();
    rx = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      tick(N);
    end
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    rst = 1'b0;
    total++;
    if (rx_byte !== 8'h00) begin
      bad++; $display("FAIL midrst_byte got=%h want=00", rx_byte);
    end
    total++;
    if (dut.state_q !== StIdle) begin
      bad++; $display("FAIL midrst_state got=%0d want=0", dut.state_q);
    end
    tick(10);
    send_frame(8'h5A, 1'b1);
    tick(20);
    total++;
    if (got_byte.size() !== 1) begin
      bad++; $display("FAIL midrst_count got=%0d want=1", got_byte.size());
    end
    if (got_byte.size() >= 1) begin
      total++;
      if (got_byte[0] !== 8'h5A) begin
        bad++; $display("FAIL midrst_rxbyte got=%h want=5a", got_byte[0]);
      end
    end
  endtask

  task automatic test_reset_in_done();
    clear_mon();
    fork
      send_frame(8'h66, 1'b1);
      begin
        tick(StrobeLat);
        total++;
        if (dut.state_q !== StDone) begin
          bad++; $display("FAIL donerst_state got=%0d want=4", dut.state_q);
        end
        rst = 1'b1;
        #1;
        total++;
        if (rx_valid !== 1'b0) begin
          bad++; $display("FAIL donerst_valid got=%b want=0", rx_valid);
        end
        tick(1);
        rst = 1'b0;
      end
    join
    tick(20);
    total++;
    if (got_byte.size() !== 0) begin
      bad++; $display("FAIL donerst_count got=%0d want=0", got_byte.size());
    end
    total++;
    if (rx_byte !== 8'h00) begin
      bad++; $display("FAIL donerst_byte got=%h want=00", rx_byte);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h01;
    exp_b[1] = 8'h80;
    exp_b[2] = 8'h7E;
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    tick(20);
    total++;
    if (got_byte.size() !== 3) begin
      bad++; $display("FAIL loop_count got=%0d want=3", got_byte.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (got_byte.size() > i) begin
        total++;
        if (got_byte[i] !== exp_b[i]) begin
          bad++; $display("FAIL loop_byte%0d got=%h want=%h", i, got_byte[i], exp_b[i]);
        end
      end
    end
    total++;
    if (ferr_cnt !== 0) begin
      bad++; $display("FAIL loop_ferr got=%0d want=0", ferr_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    test_reset();
    test_single_frame();
    test_glitch();
    test_back_to_back();
    test_bad_stop();
    test_reset_mid_frame();
    test_reset_in_done();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
